// File: rtl/reg_write_scoreboard.sv
// reg_write_scoreboard: per-register in-flight write counters feeding a decode stall; optional write-back bypass via SCOREBOARD_WB_BYPASS_EN
module reg_write_scoreboard #(
  parameter int NREG  = 8,
  parameter int AW    = 3,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic            issue_regwr,
  input  logic [AW-1:0]   issue_rd,
  input  logic            rs_use,
  input  logic [AW-1:0]   rs,
  input  logic            rt_use,
  input  logic [AW-1:0]   rt,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic            flush,
  output logic            stall,
  output logic [NREG-1:0] pending,
  output logic            err
);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic [NREG-1:0]  pend_nxt;
  logic             bypass_rs, bypass_rt;
  logic             hazard_rs, hazard_rt, full, issue_fire, wb_bad;
`ifdef SCOREBOARD_WB_BYPASS_EN
  // a read of a register retiring its last pending write this cycle gets forwarded data
  assign bypass_rs = wb_valid & (wb_rd == rs) & (cnt[rs] == ONE);
  assign bypass_rt = wb_valid & (wb_rd == rt) & (cnt[rt] == ONE);
`else
  assign bypass_rs = 1'b0;
  assign bypass_rt = 1'b0;
`endif
  // hazard detection and issue acceptance
  always_comb begin
    hazard_rs  = rs_use & (cnt[rs] != '0) & ~bypass_rs;
    hazard_rt  = rt_use & (cnt[rt] != '0) & ~bypass_rt;
    full       = issue_regwr & (cnt[issue_rd] == MAX);
    stall      = issue_valid & (hazard_rs | hazard_rt | full);
    issue_fire = issue_valid & issue_regwr & ~stall;
    wb_bad     = wb_valid & (cnt[wb_rd] == '0);
  end
  // counter next-state: issue adds, valid retire subtracts, flush clears everything
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt[i] = cnt[i];
      if (issue_fire && issue_rd == AW'(i)) cnt_nxt[i] = cnt_nxt[i] + ONE;
      if (wb_valid && wb_rd == AW'(i) && cnt[i] != '0) cnt_nxt[i] = cnt_nxt[i] - ONE;
      if (flush) cnt_nxt[i] = '0;
      pend_nxt[i] = cnt_nxt[i] != '0;
    end
  end
  // state registers; err is sticky until reset and judged on pre-flush counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      pending <= '0;
      err     <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      pending <= pend_nxt;
      err     <= err | wb_bad;
    end
  end
endmodule

// File: tb/tb_reg_write_scoreboard.sv
// tb_reg_write_scoreboard: directed scenarios plus random traffic checked against a counting model
module tb_reg_write_scoreboard;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst, issue_valid, issue_regwr, rs_use, rt_use, wb_valid, flush;
  logic [2:0] issue_rd, rs, rt, wb_rd;
  logic       stall, err;
  logic [7:0] pending;
  int         n_vec = 0, n_bad = 0;
  int         mcnt [8];
  bit         merr;

  reg_write_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_regwr(issue_regwr),
    .issue_rd(issue_rd), .rs_use(rs_use), .rs(rs), .rt_use(rt_use), .rt(rt),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .stall(stall),
    .pending(pending), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_hazard(input int r);
    return mcnt[r] > 0 && !(BYP && wb_valid && wb_rd == r && mcnt[r] == 1);
  endfunction

  function automatic bit m_stall();
    return issue_valid && ((rs_use && m_hazard(rs)) || (rt_use && m_hazard(rt)) ||
                           (issue_regwr && mcnt[issue_rd] == 3));
  endfunction

  function automatic logic [7:0] m_pending();
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = mcnt[i] > 0;
    return p;
  endfunction

  task automatic m_update();
    bit fire;
    int old;
    fire = issue_valid && issue_regwr && !m_stall();
    if (rst) begin
      for (int i = 0; i < 8; i++) mcnt[i] = 0;
      merr = 0;
      return;
    end
    old = mcnt[wb_rd];
    if (wb_valid && old == 0) merr = 1;
    if (flush) begin
      for (int i = 0; i < 8; i++) mcnt[i] = 0;
      return;
    end
    if (fire) mcnt[issue_rd]++;
    if (wb_valid && old > 0) mcnt[wb_rd]--;
  endtask

  task automatic idle();
    {rst, issue_valid, issue_regwr, rs_use, rt_use, wb_valid, flush} = '0;
    {issue_rd, rs, rt, wb_rd} = '0;
  endtask

  task automatic tick();
    #1 chk("stall", stall, m_stall());
    m_update();
    @(negedge clk);
    chk("pending", pending, m_pending());
    chk("err", err, merr);
  endtask

  task automatic issue(input int r);
    idle();
    issue_valid = 1; issue_regwr = 1; issue_rd = 3'(r);
  endtask

  task automatic wb(input int r);
    idle();
    wb_valid = 1; wb_rd = 3'(r);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mcnt[i] = 0;
    merr = 0;
    idle();
    rst = 1;
    @(negedge clk);
    tick();
    chk("rst_pending", pending, 8'h00);
    chk("rst_err", err, 0);
    // 1: issue, read hazard, retire
    issue(3); tick();
    chk("t1_pending", pending, 8'h08);
    idle(); issue_valid = 1; rs_use = 1; rs = 3;
    #1 chk("t1_stall", stall, 1);
    tick();
    wb(3); tick();
    chk("t1_retire", pending, 8'h00);
    // 2: saturation on register 5
    repeat (3) begin issue(5); tick(); end
    issue(5);
    #1 chk("t2_full_stall", stall, 1);
    tick();
    wb(5); tick(); wb(5); tick();
    chk("t2_still_pending", pending, 8'h20);
    wb(5); tick();
    chk("t2_drained", pending, 8'h00);
    chk("t2_no_err", err, 0);
    // 3: same-cycle issue and retire of register 2
    issue(2); tick();
    issue(2); wb_valid = 1; wb_rd = 2; tick();
    chk("t3_pending", pending, 8'h04);
    chk("t3_err", err, 0);
    wb(2); tick();
    chk("t3_drained", pending, 8'h00);
    // 4: retire of a non-pending register
    wb(6); tick();
    chk("t4_err", err, 1);
    idle(); tick();
    chk("t4_err_sticky", err, 1);
    chk("t4_pending", pending, 8'h00);
    idle(); rst = 1; tick();
    chk("t4_err_clr", err, 0);
    // 5: read of a register retiring its last write
    issue(1); tick();
    idle(); issue_valid = 1; rt_use = 1; rt = 1; wb_valid = 1; wb_rd = 1;
    #1 chk("t5_bypass_stall", stall, BYP ? 0 : 1);
    tick();
    chk("t5_pending", pending, 8'h00);
    // 6: flush beats same-cycle issue
    issue(2); tick(); issue(3); tick(); issue(5); tick();
    chk("t6_pending", pending, 8'h2C);
    issue(0); flush = 1; tick();
    chk("t6_flushed", pending, 8'h00);
    idle(); tick();
    chk("t6_no_issue", pending, 8'h00);
    // random traffic
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom % 64) == 0;
      flush       = ($urandom % 32) == 0;
      issue_valid = ($urandom % 4) != 0;
      issue_regwr = ($urandom % 4) != 0;
      issue_rd    = 3'($urandom_range(0, 3));
      rs_use      = ($urandom % 3) == 0;
      rs          = 3'($urandom_range(0, 7));
      rt_use      = ($urandom % 3) == 0;
      rt          = 3'($urandom_range(0, 7));
      wb_valid    = ($urandom % 3) == 0;
      wb_rd       = 3'($urandom_range(0, 3));
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
